// File: rtl/regfile_mp.sv
// regfile_mp: two-write-port register file with write-to-read bypass, optional hardwired
// zero register, and a self-clearing sweep that runs after every reset.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              init_done_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = ZERO_REG != 0;
    localparam bit BP    = BYPASS != 0;

    typedef enum logic [1:0] {RESET, CLEAR, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run, w0_ok, w1_ok;

    assign run   = state_q == RUN;
    // writes to the hardwired zero entry are dropped, so they also never bypass
    assign w0_ok = run && we0_i && !(ZR && wa0_i == '0);
    assign w1_ok = run && we1_i && !(ZR && wa1_i == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RESET;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            RESET: state_d = CLEAR;
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // port 1 is applied last so it wins an address collision
    always_ff @(posedge clk_i) begin
        if (rst_n_i && state_q == CLEAR) mem_q[cnt_q] <= '0;
        if (rst_n_i && w0_ok) mem_q[wa0_i] <= wd0_i;
        if (rst_n_i && w1_ok) mem_q[wa1_i] <= wd1_i;
    end

    assign rd1_o = (!run || (ZR && ra1_i == '0)) ? '0 :
                   (BP && w1_ok && wa1_i == ra1_i) ? wd1_i :
                   (BP && w0_ok && wa0_i == ra1_i) ? wd0_i : mem_q[ra1_i];

    assign rd2_o = (!run || (ZR && ra2_i == '0)) ? '0 :
                   (BP && w1_ok && wa1_i == ra2_i) ? wd1_i :
                   (BP && w0_ok && wa0_i == ra2_i) ? wd0_i : mem_q[ra2_i];

    assign dbg_data_o  = (!run || (ZR && dbg_addr_i == '0)) ? '0 : mem_q[dbg_addr_i];
    assign init_done_o = init_done_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors for regfile_mp, plus a no-zero-register build and a
// no-bypass build driven from the same stimulus.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa0, wa1, dbg_addr;
    logic        we0, we1;
    logic [31:0] wd0, wd1;
    logic [31:0] rd1, rd2, dbg;
    logic [31:0] rd1_nz, rd2_nz, dbg_nz;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic        done, done_nz, done_nb;
    int          n_tests = 0;
    int          n_fail = 0;
    int          k;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1), .rd2_o(rd2),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg), .init_done_o(done)
    );

    regfile_mp #(.ZERO_REG(0)) u_dut_nz (
        .clk_i(clk), .rst_n_i(rst_n), .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_nz), .rd2_o(rd2_nz),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_nz), .init_done_o(done_nz)
    );

    regfile_mp #(.BYPASS(0)) u_dut_nb (
        .clk_i(clk), .rst_n_i(rst_n), .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_nb), .rd2_o(rd2_nb),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_nb), .init_done_o(done_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // counts edges after release until init_done rises; bounded so a stuck sweep still ends
    task automatic wait_done(output int cnt, input bit poke);
        cnt = 0;
        do begin
            if (poke) begin
                we0 = 1'b1; wa0 = 5'd2; wd0 = 32'd5; ra1 = 5'd2;
            end
            tick();
            cnt++;
            if (cnt == 5) begin
                check("clear_rd1_gated", rd1, 32'h0);
                check("clear_dbg_gated", dbg, 32'h0);
            end
        end while (!done && cnt < 100);
        we0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        ra1 = 0; ra2 = 0; dbg_addr = 0;
        repeat (3) tick();
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_rd1", rd1, 32'h0);

        rst_n = 1'b1;
        wait_done(k, 1'b0);
        check("sweep_edges", k, 33);
        check("nz_done", {31'b0, done_nz}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            check($sformatf("sweep_zero_%0d", i), dbg, 32'h0);
        end

        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5; dbg_addr = 5'd5;
        #1;
        check("byp_w0_rd1", rd1, 32'hDEADBEEF);
        check("byp_dbg_nobyp", dbg, 32'h0);
        check("nb_same_cycle", rd1_nb, 32'h0);
        tick();
        we0 = 1'b0;
        #1;
        check("w0_rd1", rd1, 32'hDEADBEEF);
        check("w0_dbg", dbg, 32'hDEADBEEF);
        check("nb_next_cycle", rd1_nb, 32'hDEADBEEF);

        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222; ra2 = 5'd7;
        #1;
        check("coll_byp_rd2", rd2, 32'h2222);
        tick();
        we0 = 1'b0; we1 = 1'b0; dbg_addr = 5'd7;
        #1;
        check("coll_mem7", dbg, 32'h2222);
        check("coll_nb_rd2", rd2_nb, 32'h2222);

        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0033;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0044; ra1 = 5'd3; ra2 = 5'd4;
        #1;
        check("dual_byp_rd1", rd1, 32'h33);
        check("dual_byp_rd2", rd2, 32'h44);
        tick();
        we0 = 1'b0; we1 = 1'b0; dbg_addr = 5'd3;
        #1;
        check("dual_mem3", dbg, 32'h33);
        check("dual_mem4", rd2, 32'h44);

        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; ra1 = 5'd0; dbg_addr = 5'd0;
        #1;
        check("zero_same_rd1", rd1, 32'h0);
        check("nz_same_rd1", rd1_nz, 32'hFFFF_FFFF);
        tick();
        we1 = 1'b0;
        #1;
        check("zero_next_rd1", rd1, 32'h0);
        check("zero_next_dbg", dbg, 32'h0);
        check("nz_next_rd1", rd1_nz, 32'hFFFF_FFFF);
        check("nz_next_dbg", dbg_nz, 32'hFFFF_FFFF);

        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hABCD;
        tick();
        we0 = 1'b0; dbg_addr = 5'd9; ra1 = 5'd9;
        #1;
        check("run_mem9", dbg, 32'hABCD);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_run_done", {31'b0, done}, 32'h0);
        check("rst_run_dbg", dbg, 32'h0);
        check("rst_run_rd1", rd1, 32'h0);

        repeat (10) tick();
        check("mid_sweep_dbg9", dbg, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_done(k, 1'b1);
        check("restart_edges", k, 33);
        dbg_addr = 5'd9; ra1 = 5'd9;
        #1;
        check("after_mem9", dbg, 32'h0);
        check("after_rd1_9", rd1, 32'h0);
        dbg_addr = 5'd2;
        #1;
        check("clear_write_ignored", dbg, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
